conv1d_engine: RTL
==================

# conv1d_engine

Parametrised 1-D convolution engine; successor to the fixed 8-bit, 10-tap, file-initialised convolution core. It computes the full linear convolution z = y * h, reads y from the AIP input memory and writes z to the AIP output memory. Kernel taps are loaded at run time through a coefficient write port, and signed or unsigned arithmetic is selected per run. It sits between the AIP interface's memory, config-register and start/status ports exactly as its predecessor did.

## Interface
- DATA_W, 8, sample width of y
- COEF_W, 8, tap width of h
- OUT_W, 16, result width of z
- ADDR_W, 5, input memory address width; max Ny = 2^ADDR_W
- MAX_TAPS, 16, coefficient register-file depth (power of 2); TAP_W = clog2(MAX_TAPS)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  run request, sampled in IDLE only
- size_y_i  in  ADDR_W+1  Ny, number of input samples
- size_h_i  in  TAP_W+1  Nh, number of taps
- signed_i  in  1  1 = two's-complement y and h, 0 = unsigned
- coef_we_i  in  1  tap write strobe
- coef_addr_i  in  TAP_W  tap index
- coef_data_i  in  COEF_W  tap value
- mem_y_addr_o  out  ADDR_W  input memory read address
- data_y_i  in  DATA_W  input memory read data, valid 1 cycle after address
- mem_z_addr_o  out  ADDR_W+1  output memory write address
- data_z_o  out  OUT_W  output write data
- write_o  out  1  output write enable
- busy_o  out  1  high from the cycle after an accepted start until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  config error flag, valid with done_o, held until next start

## Operation
- Reset: all outputs 0; state IDLE; all taps 0.
- Tap writes are accepted only in IDLE: h[coef_addr_i] <= coef_data_i. Writes while busy are ignored.
- On start_i in IDLE: latch Ny, Nh and signed_i, then go to SETUP. The latched values are frozen for the whole run.
- SETUP checks the configuration. Ny = 0, Nh = 0, or Nh > MAX_TAPS sets err_o and goes to DONE with no writes.
- For n = 0 .. Ny+Nh-2: z[n] = sum of y[k]·h[n-k] for k = max(0, n-Nh+1) .. min(n, Ny-1).
- States are IDLE -> SETUP -> MAC -> DRAIN -> WRITE -> (MAC for next n | DONE) -> IDLE.
- MAC issues one y address per cycle. Each product is accumulated 1 cycle later. The accumulator is cleared on entry to MAC.
- DRAIN absorbs the final product.
- WRITE asserts write_o for 1 cycle with mem_z_addr_o = n.
- Accumulator width is ACC_W = DATA_W + COEF_W + TAP_W + 1. It never overflows internally. Products and the sum are sign-extended when signed, zero-extended otherwise.
- Output conversion from ACC_W to OUT_W is covered under Configuration.
- start_i while busy is ignored. Reset mid-run aborts immediately; no further writes occur and taps are cleared.

## Timing
- busy_o rises 1 cycle after start is sampled.
- Each output n with L_n terms takes L_n + 2 cycles (MAC, DRAIN, WRITE).
- Sum of all L_n = Ny·Nh. Total cycles from start to done_o = 1 + Ny·Nh + 2(Ny+Nh-1) + 1.
- done_o and busy_o falling occur in the same cycle. IDLE is re-entered the following cycle.
- Error run: done_o pulses 2 cycles after start with err_o = 1.
- write_o is never high in two consecutive cycles.
- mem_z_addr_o increases by 1 per write, 0 .. Ny+Nh-2.

## Configuration
- CONV1D_SAT_EN defined:
  - z is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when signed, or [0, 2^OUT_W-1] when unsigned.
  - An extra output port sat_o (1 bit) is sticky-set on any clamp and cleared at start.
- CONV1D_SAT_EN undefined:
  - data_z_o = acc[OUT_W-1:0], plain truncation.
  - No sat_o port.

## Structure
- Shared package conv_pkg holds:
  - the state enum (IDLE, SETUP, MAC, DRAIN, WRITE, DONE);
  - an ACC_W calculation function;
  - a clog2 helper.
- Sub-module conv_mac holds the registered multiply, the sign/zero extension, the accumulator with clear, and the saturation/truncation stage.
- conv1d_engine holds the FSM, the index counters and the tap register file.

## Test plan
- Unsigned: h = {1,2,3}, Ny = 4, y = {1,1,1,1} -> z = {1,3,6,6,5,3} at addresses 0..5; done_o exactly 26 cycles after start.
- Signed: h = {-1,1}, y = {5,-3} (8-bit) -> z = {-5,8,-3}.
- Ny = 0 -> err_o = 1, done_o 2 cycles after start, write_o never asserted. Repeat with Nh = MAX_TAPS+1 and expect the same result.
- Tap write and start_i while busy -> ignored; the next run uses the original taps.
- h = {127,127}, y = {127,127}, OUT_W = 8, signed: z[1] = 32258.
  - With CONV1D_SAT_EN: data_z_o = 127 and sat_o = 1.
  - Without: data_z_o = 0x02.
- Assert rst mid-MAC -> all outputs 0 immediately; taps read back as 0 (next run gives all-zero z).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the 1-D convolution engine.
package conv_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, MAC, DRAIN, WRITE, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int tap_w);
    return data_w + coef_w + tap_w + 1;
  endfunction
endpackage

// File: rtl/conv_mac.sv
// Tap operand register, sign/zero-extending multiply, clearable accumulator and
// output conversion; CONV1D_SAT_EN selects clamping instead of truncation.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              sgn,
  input  logic [DATA_W-1:0] y,
  input  logic [COEF_W-1:0] h,
  output logic [OUT_W-1:0]  z
`ifdef CONV1D_SAT_EN
  ,
  output logic              clamp
`endif
);
  localparam int PW = DATA_W + COEF_W + 2;

  logic [COEF_W-1:0]       h_q;
  logic signed [DATA_W:0]  ys;
  logic signed [COEF_W:0]  hs;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;

  // One extra bit lets a single signed multiplier serve both modes.
  assign ys   = {sgn & y[DATA_W-1], y};
  assign hs   = {sgn & h_q[COEF_W-1], h_q};
  assign prod = PW'(ys) * PW'(hs);

  // h_q lines the tap up with the one-cycle memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      acc <= '0;
    end else begin
      h_q <= h;
      if (clr)     acc <= '0;
      else if (en) acc <= acc + ACC_W'(prod);
    end
  end

`ifdef CONV1D_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((64'sd1 <<< OUT_W) - 64'sd1);

  always_comb begin
    z     = acc[OUT_W-1:0];
    clamp = 1'b0;
    if (sgn) begin
      if (acc > SMAX) begin
        z     = {1'b0, {(OUT_W-1){1'b1}}};
        clamp = 1'b1;
      end else if (acc < SMIN) begin
        z     = {1'b1, {(OUT_W-1){1'b0}}};
        clamp = 1'b1;
      end
    end else if (acc > UMAX) begin
      z     = '1;
      clamp = 1'b1;
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:OUT_W];
  assign z = acc[OUT_W-1:0];
`endif
endmodule

// File: rtl/conv1d_engine.sv
// Full linear convolution z = y * h over AIP memories with run-time taps.
// Optional CONV1D_SAT_EN adds output clamping and the sticky sat_o flag.
module conv1d_engine
  import conv_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int COEF_W   = 8,
  parameter  int OUT_W    = 16,
  parameter  int ADDR_W   = 5,
  parameter  int MAX_TAPS = 16,
  localparam int TAP_W    = clog2(MAX_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W:0]   size_y_i,
  input  logic [TAP_W:0]    size_h_i,
  input  logic              signed_i,
  input  logic              coef_we_i,
  input  logic [TAP_W-1:0]  coef_addr_i,
  input  logic [COEF_W-1:0] coef_data_i,
  output logic [ADDR_W-1:0] mem_y_addr_o,
  input  logic [DATA_W-1:0] data_y_i,
  output logic [ADDR_W:0]   mem_z_addr_o,
  output logic [OUT_W-1:0]  data_z_o,
  output logic              write_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef CONV1D_SAT_EN
  ,
  output logic              sat_o
`endif
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAP_W);
  localparam int CW    = ADDR_W + 3;

  state_t state, nxt;
  logic [ADDR_W:0]                 ny;
  logic [TAP_W:0]                  nh;
  logic                            sgn;
  logic [ADDR_W:0]                 n;
  logic [ADDR_W-1:0]               k;
  logic [TAP_W-1:0]                t;
  logic [MAX_TAPS-1:0][COEF_W-1:0] taps;
  logic                            vld_q;
  logic [CW-1:0] n_w, k_w, ny_w, nh_w, k_hi, k_lo_nx, t_nx;
  logic cfg_err, last, clr;

  assign n_w  = CW'(n);
  assign k_w  = CW'(k);
  assign ny_w = CW'(ny);
  assign nh_w = CW'(nh);

  assign cfg_err = (ny == '0) || (nh == '0) || (nh_w > CW'(MAX_TAPS));
  assign last    = (n_w == ny_w + nh_w - CW'(2));
  assign k_hi    = (n_w < ny_w) ? n_w : ny_w - CW'(1);
  // Start of the k window for n+1; t tracks the matching tap index n-k.
  assign k_lo_nx = (n_w + CW'(2) > nh_w) ? n_w + CW'(2) - nh_w : '0;
  assign t_nx    = (n_w + CW'(2) > nh_w) ? nh_w - CW'(1) : n_w + CW'(1);
  assign clr     = (nxt == MAC) && (state != MAC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_i) nxt = SETUP;
      SETUP:   nxt = cfg_err ? DONE : MAC;
      MAC:     if (k_w == k_hi) nxt = DRAIN;
      DRAIN:   nxt = WRITE;
      WRITE:   nxt = last ? DONE : MAC;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ny     <= '0;
      nh     <= '0;
      sgn    <= 1'b0;
      n      <= '0;
      k      <= '0;
      t      <= '0;
      taps   <= '0;
      vld_q  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      vld_q  <= (state == MAC);
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we_i) taps[coef_addr_i] <= coef_data_i;
          if (start_i) begin
            ny     <= size_y_i;
            nh     <= size_h_i;
            sgn    <= signed_i;
            busy_o <= 1'b1;
            err_o  <= 1'b0;
          end
        end
        SETUP: begin
          n     <= '0;
          k     <= '0;
          t     <= '0;
          err_o <= cfg_err;
        end
        MAC: if (k_w != k_hi) begin
          k <= k + ADDR_W'(1);
          t <= t - TAP_W'(1);
        end
        WRITE: begin
          n <= n + (ADDR_W+1)'(1);
          k <= ADDR_W'(k_lo_nx);
          t <= TAP_W'(t_nx);
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_y_addr_o = k;
  assign mem_z_addr_o = n;
  assign write_o      = (state == WRITE);

`ifdef CONV1D_SAT_EN
  logic clamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          sat_o <= 1'b0;
    else if (state == IDLE && start_i) sat_o <= 1'b0;
    else if (write_o && clamp)         sat_o <= 1'b1;
  end
`endif

  conv_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (vld_q),
    .sgn  (sgn),
    .y    (data_y_i),
    .h    (taps[t]),
    .z    (data_z_o)
`ifdef CONV1D_SAT_EN
    ,
    .clamp(clamp)
`endif
  );
endmodule
